// File: rtl/proc_bus_pkg.sv
// Shared types and constants for the processor bus arbitration slice.
package proc_bus_pkg;

  localparam int unsigned N_BUS_REQ = 4;
  localparam int unsigned BUS_IDX_W = 2;

  typedef logic [BUS_IDX_W-1:0] bus_idx_t;
  typedef logic [N_BUS_REQ-1:0] bus_req_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Requester index to one-hot grant vector
  function automatic bus_req_t idx_to_onehot(input bus_idx_t idx);
    bus_req_t oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/four_one_mux.sv
// Four-input data selector feeding the shared bus; output forced to zero when disabled.
module four_one_mux
  import proc_bus_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] d0,
  input  logic [DATA_WIDTH-1:0] d1,
  input  logic [DATA_WIDTH-1:0] d2,
  input  logic [DATA_WIDTH-1:0] d3,
  input  bus_idx_t              sel,
  input  logic                  en,
  output logic [DATA_WIDTH-1:0] y
);

  // Select one source; an idle bus carries zeros
  always_comb begin
    y = '0;
    if (en) begin
      case (sel)
        2'd0:    y = d0;
        2'd1:    y = d1;
        2'd2:    y = d2;
        default: y = d3;
      endcase
    end
  end

endmodule

// File: rtl/bus_grant_arbiter.sv
// Round-robin arbiter granting the shared processor bus to one of four requesters,
// with a bounded hold time and a one-cycle overrun flag.
module bus_grant_arbiter
  import proc_bus_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAX_HOLD   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_BUS_REQ-1:0]  req,
  input  logic                  done,
  input  logic [DATA_WIDTH-1:0] data_in0,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic [DATA_WIDTH-1:0] data_in2,
  input  logic [DATA_WIDTH-1:0] data_in3,
  output logic [N_BUS_REQ-1:0]  gnt,
  output logic [1:0]            bus_sel,
  output logic                  bus_valid,
  output logic [DATA_WIDTH-1:0] bus_data,
  output logic                  timeout_err
);

  localparam int unsigned HW        = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [HW-1:0] HOLD_SAT  = '1;

  arb_state_t      state_q, state_d;
  bus_req_t        gnt_q, gnt_d;
  bus_idx_t        sel_q, sel_d;
  logic            valid_q, valid_d;
  logic            terr_q, terr_d;
  logic [HW-1:0]   hold_q, hold_d;
  bus_idx_t        last_q, last_d;

  bus_idx_t        winner;
  logic            rel_done, rel_wd, rel_to, release_c;

  // Rotate requests so last+1 sits at bit 0, take the lowest set bit, rotate back
  function automatic bus_idx_t rr_pick(input bus_req_t r, input bus_idx_t last);
    bus_idx_t base;
    bus_req_t rot;
    bus_idx_t enc;
    base = last + bus_idx_t'(1);
    for (int i = 0; i < N_BUS_REQ; i++) begin
      rot[i] = r[base + bus_idx_t'(i)];
    end
    enc = '0;
    for (int i = N_BUS_REQ - 1; i >= 0; i--) begin
      if (rot[i]) enc = bus_idx_t'(i);
    end
    return base + enc;
  endfunction

  // Release qualifiers for the current grant; done outranks the hold limit
  always_comb begin
    winner    = rr_pick(req, last_q);
    rel_done  = done;
    rel_wd    = ~req[sel_q];
    rel_to    = (hold_q == HOLD_LAST) && !rel_done && !rel_wd;
    release_c = rel_done | rel_wd | rel_to;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ARB_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (|req)     state_d = ARB_BUSY;
      ARB_BUSY: if (release_c) state_d = ARB_IDLE;
      default:                state_d = ARB_IDLE;
    endcase
  end

  // Next values of the registered outputs and arbitration bookkeeping
  always_comb begin
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    terr_d  = 1'b0;
    hold_d  = hold_q;
    last_d  = last_q;
    case (state_q)
      ARB_IDLE: begin
        if (|req) begin
          gnt_d   = idx_to_onehot(winner);
          sel_d   = winner;
          valid_d = 1'b1;
          hold_d  = '0;
        end else begin
          gnt_d   = '0;
          valid_d = 1'b0;
        end
      end
      ARB_BUSY: begin
        if (release_c) begin
          gnt_d   = '0;
          valid_d = 1'b0;
          last_d  = sel_q;
          terr_d  = rel_to;
          hold_d  = '0;
        end else if (hold_q != HOLD_SAT) begin
          hold_d  = hold_q + HW'(1);
        end
      end
      default: begin
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // Output and bookkeeping registers; last resets to 3 so requester 0 wins first
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      terr_q  <= 1'b0;
      hold_q  <= '0;
      last_q  <= bus_idx_t'(N_BUS_REQ - 1);
    end else begin
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      terr_q  <= terr_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end

  // Bus data path: zero-latency from the data inputs, gated by the active grant
  four_one_mux #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mux (
    .d0  (data_in0),
    .d1  (data_in1),
    .d2  (data_in2),
    .d3  (data_in3),
    .sel (sel_q),
    .en  (valid_q),
    .y   (bus_data)
  );

  assign gnt         = gnt_q;
  assign bus_sel     = sel_q;
  assign bus_valid   = valid_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_bus_grant_arbiter.sv
// Directed self-checking bench for bus_grant_arbiter.
module tb_bus_grant_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic        done;
  logic [15:0] data_in0, data_in1, data_in2, data_in3;
  logic [3:0]  gnt;
  logic [1:0]  bus_sel;
  logic        bus_valid;
  logic [15:0] bus_data;
  logic        timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] exp_seq [0:4];

  bus_grant_arbiter #(.DATA_WIDTH(16), .MAX_HOLD(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .done        (done),
    .data_in0    (data_in0),
    .data_in1    (data_in1),
    .data_in2    (data_in2),
    .data_in3    (data_in3),
    .gnt         (gnt),
    .bus_sel     (bus_sel),
    .bus_valid   (bus_valid),
    .bus_data    (bus_data),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; sample and drive 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    done  = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    data_in0 = 16'h1111;
    data_in1 = 16'h2222;
    data_in2 = 16'h3333;
    data_in3 = 16'h4444;
    do_reset();
    n_tests++;
    if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got %b want 0000", gnt); end
    n_tests++;
    if (bus_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus_valid); end
    n_tests++;
    if (bus_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data got %h want 0000", bus_data); end
    n_tests++;
    if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_terr got %b want 0", timeout_err); end
    n_tests++;
    if (bus_sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel got %0d want 0", bus_sel); end
    req = 4'b1111;
    step();
    n_tests++;
    if (gnt !== 4'b0001) begin n_fail++; $display("FAIL first_grant got %b want 0001", gnt); end
    n_tests++;
    if (bus_data !== 16'h1111) begin n_fail++; $display("FAIL first_data got %h want 1111", bus_data); end
  endtask

  task automatic test_rotation();
    exp_seq[0] = 4'b0001;
    exp_seq[1] = 4'b0010;
    exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000;
    exp_seq[4] = 4'b0001;
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      n_tests++;
      if (gnt !== exp_seq[k]) begin n_fail++; $display("FAIL rot_gnt[%0d] got %b want %b", k, gnt, exp_seq[k]); end
      n_tests++;
      if (bus_sel !== 2'(k % 4)) begin n_fail++; $display("FAIL rot_sel[%0d] got %0d want %0d", k, bus_sel, k % 4); end
      step();
      n_tests++;
      if (gnt !== exp_seq[k]) begin n_fail++; $display("FAIL rot_hold[%0d] got %b want %b", k, gnt, exp_seq[k]); end
      done = 1'b1;
      step();
      done = 1'b0;
      n_tests++;
      if (gnt !== 4'b0000 || bus_valid !== 1'b0 || bus_data !== 16'h0000) begin
        n_fail++;
        $display("FAIL rot_idle[%0d] got gnt=%b valid=%b data=%h want 0000/0/0000", k, gnt, bus_valid, bus_data);
      end
      n_tests++;
      if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rot_terr[%0d] got %b want 0", k, timeout_err); end
    end
    req = 4'b0000;
  endtask

  task automatic test_timeout();
    do_reset();
    data_in2 = 16'hBEEF;
    req = 4'b0100;
    step();
    for (int c = 0; c < 8; c++) begin
      n_tests++;
      if (gnt !== 4'b0100 || bus_data !== 16'hBEEF || timeout_err !== 1'b0) begin
        n_fail++;
        $display("FAIL to_hold[%0d] got gnt=%b data=%h terr=%b want 0100/beef/0", c, gnt, bus_data, timeout_err);
      end
      if (c == 4) begin
        data_in2 = 16'h1234;
        #1;
        n_tests++;
        if (bus_data !== 16'h1234) begin n_fail++; $display("FAIL to_live_data got %h want 1234", bus_data); end
        data_in2 = 16'hBEEF;
        #1;
      end
      step();
    end
    n_tests++;
    if (gnt !== 4'b0000 || bus_valid !== 1'b0 || bus_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL to_release got gnt=%b valid=%b data=%h want 0000/0/0000", gnt, bus_valid, bus_data);
    end
    n_tests++;
    if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_pulse got %b want 1", timeout_err); end
    n_tests++;
    if (bus_sel !== 2'd2) begin n_fail++; $display("FAIL to_sel_hold got %0d want 2", bus_sel); end
    req = 4'b0000;
    step();
    n_tests++;
    if (timeout_err !== 1'b0 || gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL to_pulse_end got terr=%b gnt=%b want 0/0000", timeout_err, gnt);
    end
  endtask

  task automatic test_done_at_limit();
    do_reset();
    req = 4'b0001;
    step();
    for (int c = 0; c < 7; c++) step();
    n_tests++;
    if (gnt !== 4'b0001) begin n_fail++; $display("FAIL lim_hold7 got %b want 0001", gnt); end
    done = 1'b1;
    step();
    done = 1'b0;
    n_tests++;
    if (gnt !== 4'b0000 || timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL lim_done got gnt=%b terr=%b want 0000/0", gnt, timeout_err);
    end
    req = 4'b0000;
  endtask

  task automatic test_withdraw();
    do_reset();
    req = 4'b0010;
    step();
    n_tests++;
    if (gnt !== 4'b0010) begin n_fail++; $display("FAIL wd_grant got %b want 0010", gnt); end
    step();
    req = 4'b0000;
    step();
    n_tests++;
    if (gnt !== 4'b0000 || timeout_err !== 1'b0 || bus_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_release got gnt=%b terr=%b valid=%b want 0000/0/0", gnt, timeout_err, bus_valid);
    end
    n_tests++;
    if (bus_sel !== 2'd1) begin n_fail++; $display("FAIL wd_sel_hold got %0d want 1", bus_sel); end
    req = 4'b1111;
    step();
    n_tests++;
    if (gnt !== 4'b0100) begin n_fail++; $display("FAIL wd_next_after_last1 got %b want 0100", gnt); end
    req = 4'b0000;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b1000;
    step();
    n_tests++;
    if (gnt !== 4'b1000) begin n_fail++; $display("FAIL rmg_grant got %b want 1000", gnt); end
    step();
    reset = 1'b1;
    step();
    n_tests++;
    if (gnt !== 4'b0000 || bus_valid !== 1'b0 || bus_sel !== 2'd0 || timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rmg_reset got gnt=%b valid=%b sel=%0d terr=%b want 0000/0/0/0", gnt, bus_valid, bus_sel, timeout_err);
    end
    reset = 1'b0;
    req = 4'b1001;
    step();
    n_tests++;
    if (gnt !== 4'b0001) begin n_fail++; $display("FAIL rmg_regrant got %b want 0001", gnt); end
    req = 4'b0000;
  endtask

  initial begin
    reset    = 1'b1;
    req      = 4'b0000;
    done     = 1'b0;
    data_in0 = 16'h0000;
    data_in1 = 16'h0000;
    data_in2 = 16'h0000;
    data_in3 = 16'h0000;
    test_reset();
    test_rotation();
    test_timeout();
    test_done_at_limit();
    test_withdraw();
    test_reset_mid_grant();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
